// File: rtl/rv_pkg.sv
// Shared fetch-side types and constants: XLEN, reset vector, instruction size
// and the instruction-queue entry layout.
package rv_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam int          INSTR_BYTES  = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            filled;
  } ifq_entry_t;
endpackage

// File: rtl/ifetch_queue_storage.sv
// ifq_storage: DEPTH-entry circular buffer with head (oldest), tail (next free)
// and fill (oldest pending) pointers. Flush empties it in one cycle.
module ifq_storage
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             i_flush,
  input  logic             i_alloc,
  input  logic [XLEN-1:0]  i_alloc_pc,
  input  logic             i_fill,
  input  logic [XLEN-1:0]  i_fill_data,
  input  logic             i_pop,
  output ifq_entry_t       o_head,
  output logic [CNT_W-1:0] o_occ,
  output logic [CNT_W-1:0] o_pend
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ifq_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_fptr;
  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] r_pend;

  // Alloc, fill and pop always target distinct entries, so their writes never collide.
  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_fptr <= '0;
      r_occ  <= '0;
      r_pend <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i].filled <= 1'b0;
    end else begin
      if (i_alloc) begin
        r_mem[r_tail].pc     <= i_alloc_pc;
        r_mem[r_tail].filled <= 1'b0;
        r_tail               <= r_tail + PTR_W'(1);
      end
      if (i_fill) begin
        r_mem[r_fptr].data   <= i_fill_data;
        r_mem[r_fptr].filled <= 1'b1;
        r_fptr               <= r_fptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_mem[r_head].filled <= 1'b0;
        r_head               <= r_head + PTR_W'(1);
      end
      r_occ  <= r_occ + CNT_W'(i_alloc) - CNT_W'(i_pop);
      r_pend <= r_pend + CNT_W'(i_alloc) - CNT_W'(i_fill);
    end
  end

  assign o_head = r_mem[r_head];
  assign o_occ  = r_occ;
  assign o_pend = r_pend;
endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues fetches at current_pc, buffers responses in order,
// flushes on redirect. Optional misaligned-PC trap under IFETCH_MISALIGN_TRAP_EN.
module ifetch_queue #(
  parameter int          DEPTH        = 2,
  parameter logic [31:0] RESET_VECTOR = rv_pkg::RESET_VECTOR,
  parameter int          CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  output logic [31:0] next_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fetch_misaligned
);
  import rv_pkg::*;

  ifq_entry_t       w_head;
  logic [CNT_W-1:0] w_occ;
  logic [CNT_W-1:0] w_pend;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W:0]   w_inflight;
  logic             w_misal;
  logic             w_hs;
  logic             w_resp_drop;
  logic             w_resp_fill;
  logic             w_pop;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic r_misaligned;
  assign w_misal = (current_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset || redirect_valid) r_misaligned <= 1'b0;
    else if (w_misal)            r_misaligned <= 1'b1;
  end
  assign fetch_misaligned = r_misaligned;
`else
  assign w_misal          = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  // Entries still owed a response by memory plus ones it will answer for a flushed
  // epoch; capping their sum bounds what the memory ever holds outstanding.
  assign w_inflight     = {1'b0, w_occ} + {1'b0, r_drop_cnt};
  assign imem_req_valid = !reset && !redirect_valid && !w_misal &&
                          (w_inflight < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = current_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;

  assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
  assign w_resp_fill = imem_resp_valid && (r_drop_cnt == '0) && (w_pend != '0);

  assign instr_valid = w_head.filled && !redirect_valid && !reset;
  assign instr_data  = w_head.data;
  assign instr_pc    = w_head.pc;
  assign w_pop       = instr_valid && instr_ready;

  always_comb begin
    next_pc = current_pc;
    if (reset)               next_pc = RESET_VECTOR;
    else if (redirect_valid) next_pc = redirect_target;
    else if (w_hs)           next_pc = current_pc + XLEN'(INSTR_BYTES);
  end

  ifq_storage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_storage (
    .clk         (clk),
    .i_flush     (reset || redirect_valid),
    .i_alloc     (w_hs),
    .i_alloc_pc  (current_pc),
    .i_fill      (w_resp_fill && !redirect_valid && !reset),
    .i_fill_data (imem_resp_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ),
    .o_pend      (w_pend)
  );

  // On redirect every pending entry becomes a response to discard, except one
  // that lands in the redirect cycle itself.
  always_ff @(posedge clk) begin
    if (reset)
      r_drop_cnt <= '0;
    else if (redirect_valid)
      r_drop_cnt <= r_drop_cnt - CNT_W'(w_resp_drop) + w_pend - CNT_W'(w_resp_fill);
    else
      r_drop_cnt <= r_drop_cnt - CNT_W'(w_resp_drop);
  end

  ap_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    !(imem_resp_valid && (r_drop_cnt == '0) && (w_pend == '0)));
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=2): models the PC register and a
// 1-cycle instruction memory, checks with immediate assertions.
module tb_ifetch_queue;
  localparam logic [31:0] RV = 32'h8000_0000;
  localparam logic [31:0] K  = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] current_pc = 32'h0;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_misaligned;

  int checks = 0;
  int failures = 0;
  bit auto_mem = 1'b1;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .current_pc(current_pc), .next_pc(next_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: PC register loads next_pc; memory answers a handshake one cycle later.
  task automatic tick();
    logic [31:0] npc;
    logic        hs;
    logic [31:0] a;
    npc = next_pc;
    hs  = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    current_pc = npc;
    if (auto_mem) begin
      imem_resp_valid = hs;
      imem_resp_data  = a ^ K;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b0;
    auto_mem = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    chk("rst_next_pc", next_pc, RV);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_instr(input logic [31:0] exp_pc);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (instr_valid === 1'b1) begin
        got = 1'b1;
        chk("instr_pc", instr_pc, exp_pc);
        chk("instr_data", instr_data, exp_pc ^ K);
      end
      tick();
    end
    chk("instr_arrived", {31'b0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and first request
    do_reset();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, RV);
    chk("first_next_pc", next_pc, 32'h8000_0004);

    // In-order delivery with ready memory and decode
    instr_ready = 1'b1;
    wait_instr(32'h8000_0000);
    wait_instr(32'h8000_0004);
    wait_instr(32'h8000_0008);

    // Full queue stalls requests and holds next_pc
    do_reset();
    instr_ready = 1'b0;
    tick();
    tick();
    chk("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("full_next_pc", next_pc, 32'h8000_0008);
    tick();
    chk("full_req_valid2", {31'b0, imem_req_valid}, 32'd0);
    chk("full_next_pc2", next_pc, 32'h8000_0008);
    chk("full_head_valid", {31'b0, instr_valid}, 32'd1);
    chk("full_head_pc", instr_pc, 32'h8000_0000);
    instr_ready = 1'b1;
    #1;
    tick();
    chk("pop_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("pop_req_addr", imem_req_addr, 32'h8000_0008);
    chk("pop_next_pc", next_pc, 32'h8000_000C);

    // Redirect with two requests outstanding: both responses dropped
    do_reset();
    auto_mem = 1'b0;
    tick();
    tick();
    chk("rd_req_stall", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0100;
    #1;
    chk("rd_next_pc", next_pc, 32'h8000_0100);
    chk("rd_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("rd_drop_stall", {31'b0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    #1;
    tick();
    chk("rd_drop1_iv", {31'b0, instr_valid}, 32'd0);
    tick();
    imem_resp_valid = 1'b0;
    #1;
    chk("rd_drop2_iv", {31'b0, instr_valid}, 32'd0);
    chk("rd_resume_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rd_resume_addr", imem_req_addr, 32'h8000_0100);
    chk("rd_hold_next_pc", next_pc, 32'h8000_0100);
    imem_req_ready = 1'b1;
    auto_mem = 1'b1;
    #1;
    wait_instr(32'h8000_0100);

    // Redirect coinciding with a live response and a consume handshake
    do_reset();
    auto_mem = 1'b0;
    instr_ready = 1'b0;
    tick();
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = RV ^ K;
    #1;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    chk("co_head_valid", {31'b0, instr_valid}, 32'd1);
    chk("co_head_pc", instr_pc, RV);
    instr_ready = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h8000_0004 ^ K;
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0300;
    #1;
    chk("co_iv_masked", {31'b0, instr_valid}, 32'd0);
    chk("co_next_pc", next_pc, 32'h8000_0300);
    tick();
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    chk("co_flushed_iv", {31'b0, instr_valid}, 32'd0);
    chk("co_resume_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("co_resume_addr", imem_req_addr, 32'h8000_0300);
    auto_mem = 1'b1;
    #1;
    wait_instr(32'h8000_0300);
    wait_instr(32'h8000_0304);

    // Redirect while streaming, to the top of the address space (PC wraps)
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    #1;
    tick();
    redirect_valid = 1'b0;
    #1;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        if (imem_req_valid === 1'b1) seen = 1'b1;
        else tick();
      end
      chk("wrap_req_seen", {31'b0, seen}, 32'd1);
    end
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_next_pc", next_pc, 32'h0000_0000);
    wait_instr(32'hFFFF_FFFC);
    wait_instr(32'h0000_0000);

    // Reset mid-operation clears the queue
    do_reset();
    chk("post_rst_iv", {31'b0, instr_valid}, 32'd0);
    chk("post_rst_addr", imem_req_addr, RV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
